// File: rtl/gpio_pkg.sv
// Shared register map for the memory-mapped GPIO bank: per-channel offsets,
// channel stride and address-split helpers.
package gpio_pkg;

  localparam logic [4:0] GPIO_OUT_OFS  = 5'h00;
  localparam logic [4:0] GPIO_IN_OFS   = 5'h04;
  localparam logic [4:0] GPIO_IE_OFS   = 5'h08;
  localparam logic [4:0] GPIO_RISE_OFS = 5'h0C;
  localparam logic [4:0] GPIO_FALL_OFS = 5'h10;
  localparam logic [4:0] GPIO_PEND_OFS = 5'h14;

  localparam logic [7:0] CH_STRIDE = 8'h20;

  typedef enum logic [4:0] {
    REG_OUT  = GPIO_OUT_OFS,
    REG_IN   = GPIO_IN_OFS,
    REG_IE   = GPIO_IE_OFS,
    REG_RISE = GPIO_RISE_OFS,
    REG_FALL = GPIO_FALL_OFS,
    REG_PEND = GPIO_PEND_OFS
  } gpio_reg_e;

  // Channel number of a byte address; 8 channels fill the 8-bit window.
  function automatic logic [2:0] chIndex(input logic [7:0] a);
    return 3'(a / CH_STRIDE);
  endfunction

  // Word-aligned register offset within a channel.
  function automatic logic [4:0] regOffset(input logic [7:0] a);
    return {a[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/gpio_channel.sv
// One GPIO channel: 2-flop synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// edge detection, OUT/IE/RISE_EN/FALL_EN registers and sticky W1C pending bits.
module gpio_channel
  import gpio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             wrEn,
  input  logic [4:0]       regOfs,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rdData,
  output logic [WIDTH-1:0] outReg,
  output logic             irqReq
);

  logic [WIDTH-1:0] s1, s2, f, prev;
  logic [WIDTH-1:0] ie, riseEn, fallEn, pend;
  logic [WIDTH-1:0] setBits, clrBits;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= pin;
      s2   <= s1;
      prev <= f;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] dbCnt [WIDTH];

  // f follows s2 only once s2 has disagreed with it for DB_CYCLES edges in a row.
  // NOTE: the counter array is reset like any other flop; it is state, not storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f <= '0;
      for (int i = 0; i < WIDTH; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == f[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == CW'(DB_CYCLES - 1)) begin
          f[i]     <= s2[i];
          dbCnt[i] <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + CW'(1);
        end
      end
    end
  end
`else
  localparam int unusedDbCycles = DB_CYCLES;

  assign f = s2;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    setBits = ((f & ~prev) & riseEn) | ((~f & prev) & fallEn);
    clrBits = '0;
    if (wrEn && regOfs == REG_PEND) clrBits = wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outReg <= '0;
      ie     <= '0;
      riseEn <= '0;
      fallEn <= '0;
    end else if (wrEn) begin
      case (regOfs)
        REG_OUT:  outReg <= wd;
        REG_IE:   ie     <= wd;
        REG_RISE: riseEn <= wd;
        REG_FALL: fallEn <= wd;
        default:  ;
      endcase
    end
  end

  // A new edge in the same cycle as a W1C write keeps its bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= (pend & ~clrBits) | setBits;
  end

  always_comb begin
    rdData = '0;
    case (regOfs)
      REG_OUT:  rdData = outReg;
      REG_IN:   rdData = f;
      REG_IE:   rdData = ie;
      REG_RISE: rdData = riseEn;
      REG_FALL: rdData = fallEn;
      REG_PEND: rdData = pend;
      default:  rdData = '0;
    endcase
  end

  assign irqReq = |(pend & ie);

endmodule

// File: rtl/gpio_bank_mm.sv
// Memory-mapped bank of CHANNELS GPIO channels with one registered level interrupt.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank_mm
  import gpio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int DB_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sel,
  input  logic                      we,
  input  logic [7:0]                addr,
  input  logic [31:0]               wd,
  output logic [31:0]               rd,
  input  logic [CHANNELS*WIDTH-1:0] gpio_in,
  output logic [CHANNELS*WIDTH-1:0] gpio_out,
  output logic                      irq
);

  logic [2:0]          chSel;
  logic [4:0]          regOfs;
  logic [WIDTH-1:0]    chRd [CHANNELS];
  logic [CHANNELS-1:0] irqVec;
  logic [WIDTH-1:0]    rdMux;
  logic [31:0]         unusedWd;
  logic [1:0]          unusedAddr;

  assign chSel      = chIndex(addr);
  assign regOfs     = regOffset(addr);
  assign unusedWd   = wd;
  assign unusedAddr = addr[1:0];

  for (genvar c = 0; c < CHANNELS; c++) begin : gCh
    gpio_channel #(
      .WIDTH     (WIDTH),
      .DB_CYCLES (DB_CYCLES)
    ) uCh (
      .clk    (clk),
      .rst    (rst),
      .pin    (gpio_in[c*WIDTH +: WIDTH]),
      .wrEn   (sel && we && chSel == 3'(c)),
      .regOfs (regOfs),
      .wd     (wd[WIDTH-1:0]),
      .rdData (chRd[c]),
      .outReg (gpio_out[c*WIDTH +: WIDTH]),
      .irqReq (irqVec[c])
    );
  end

  // Channels beyond CHANNELS never match, so their window reads as zero.
  always_comb begin
    rdMux = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel && chSel == 3'(c)) rdMux = chRd[c];
    end
    rd = 32'(rdMux);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= |irqVec;
  end

endmodule

// File: tb/tb_gpio_bank_mm.sv
// Self-checking bench for gpio_bank_mm: vector table, directed latency/race/reset
// sequences and randomized traffic against a register-level reference model.
module tb_gpio_bank_mm;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;
  localparam int NB       = WIDTH * CHANNELS;

  logic          clk = 1'b0;
  logic          rst;
  logic          sel, we;
  logic [7:0]    addr;
  logic [31:0]   wd, rd;
  logic [NB-1:0] gpio_in, gpio_out;
  logic          irq;

  always #5 clk = ~clk;

  gpio_bank_mm #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DB_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers plus the pin value seen at each clock edge.
  logic [WIDTH-1:0] mOut [CHANNELS];
  logic [WIDTH-1:0] mIe  [CHANNELS];
  logic [WIDTH-1:0] mRise[CHANNELS];
  logic [WIDTH-1:0] mFall[CHANNELS];
  logic [WIDTH-1:0] mPend[CHANNELS];
  logic             mIrq;
  logic [NB-1:0]    pinQ[$];
  bit               modelOn = 1'b1;

  function automatic void modelReset();
    for (int c = 0; c < CHANNELS; c++) begin
      mOut[c] = '0; mIe[c] = '0; mRise[c] = '0; mFall[c] = '0; mPend[c] = '0;
    end
    mIrq = 1'b0;
    pinQ.delete();
    repeat (3) pinQ.push_back('0);
  endfunction

  // The pin value a channel reports is the one sampled two edges before the current one.
  function automatic logic [WIDTH-1:0] seenPins(int c, int edgesBack);
    logic [NB-1:0] v;
    v = pinQ[pinQ.size() - edgesBack];
    return v[c*WIDTH +: WIDTH];
  endfunction

  function automatic logic [31:0] modelRead(input bit s, input logic [7:0] a);
    int ch, ofs;
    if (!s) return 32'h0;
    ch  = int'(a) / 32;
    ofs = int'(a) % 32 / 4 * 4;
    if (ch >= CHANNELS) return 32'h0;
    case (ofs)
      'h00: return 32'(mOut[ch]);
      'h04: return 32'(seenPins(ch, 2));
      'h08: return 32'(mIe[ch]);
      'h0C: return 32'(mRise[ch]);
      'h10: return 32'(mFall[ch]);
      'h14: return 32'(mPend[ch]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void modelEdge(input bit s, input bit w, input logic [7:0] a,
                                    input logic [31:0] d, input logic [NB-1:0] pins);
    bit               anyIrq;
    int               ch, ofs;
    logic [WIDTH-1:0] now, old, setB, clrB;
    anyIrq = 1'b0;
    ch  = int'(a) / 32;
    ofs = int'(a) % 32 / 4 * 4;
    for (int c = 0; c < CHANNELS; c++) anyIrq |= |(mPend[c] & mIe[c]);
    for (int c = 0; c < CHANNELS; c++) begin
      now  = seenPins(c, 2);
      old  = seenPins(c, 3);
      setB = (now & ~old & mRise[c]) | (~now & old & mFall[c]);
      clrB = (s && w && ch == c && ofs == 'h14) ? d[WIDTH-1:0] : '0;
      mPend[c] = (mPend[c] & ~clrB) | setB;
    end
    if (s && w && ch < CHANNELS) begin
      case (ofs)
        'h00: mOut[ch]  = d[WIDTH-1:0];
        'h08: mIe[ch]   = d[WIDTH-1:0];
        'h0C: mRise[ch] = d[WIDTH-1:0];
        'h10: mFall[ch] = d[WIDTH-1:0];
        default: ;
      endcase
    end
    mIrq = anyIrq;
    pinQ.push_back(pins);
    if (pinQ.size() > 4) void'(pinQ.pop_front());
  endfunction

  function automatic logic [NB-1:0] modelOutBus();
    logic [NB-1:0] v;
    for (int c = 0; c < CHANNELS; c++) v[c*WIDTH +: WIDTH] = mOut[c];
    return v;
  endfunction

  // One bus cycle: drive after an edge, sample rd before the next, then check post-edge state.
  task automatic doCycle(input bit s, input bit w, input logic [7:0] a, input logic [31:0] d,
                         input logic [NB-1:0] pins, output logic [31:0] rdSeen);
    sel = s; we = w; addr = a; wd = d; gpio_in = pins;
    #1;
    rdSeen = rd;
    if (modelOn) check($sformatf("model rd a=%0h", a), rd, modelRead(s, a));
    @(posedge clk);
    modelEdge(s, w, a, d, pins);
    #1;
    if (modelOn) begin
      check("model gpio_out", 32'(gpio_out), 32'(modelOutBus()));
      check("model irq", 32'(irq), 32'(mIrq));
    end
  endtask

  task automatic idle(input int n, input logic [7:0] a, input logic [NB-1:0] pins,
                      output logic [31:0] rdSeen);
    for (int i = 0; i < n; i++) doCycle(1'b1, 1'b0, a, 32'h0, pins, rdSeen);
  endtask

  typedef struct {
    bit            s;
    bit            w;
    logic [7:0]    a;
    logic [31:0]   d;
    logic [31:0]   expRd;
    logic [NB-1:0] expOut;
    string         name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r;
    logic [NB-1:0] pins;

    vecs.push_back('{1, 1, 8'h20, 32'h0000_01A5, 32'h00, 16'hA500, "wr ch1 OUT"});
    vecs.push_back('{1, 0, 8'h20, 32'h0,         32'hA5, 16'hA500, "rd ch1 OUT"});
    vecs.push_back('{1, 1, 8'h08, 32'hFFFF_FF3C, 32'h00, 16'hA500, "wr ch0 IE"});
    vecs.push_back('{1, 0, 8'h08, 32'h0,         32'h3C, 16'hA500, "rd ch0 IE"});
    vecs.push_back('{1, 1, 8'h18, 32'hFF,        32'h00, 16'hA500, "wr hole 0x18"});
    vecs.push_back('{1, 1, 8'h40, 32'hFF,        32'h00, 16'hA500, "wr ch2 0x40"});
    vecs.push_back('{1, 0, 8'h18, 32'h0,         32'h00, 16'hA500, "rd hole 0x18"});
    vecs.push_back('{1, 0, 8'h40, 32'h0,         32'h00, 16'hA500, "rd ch2 0x40"});
    vecs.push_back('{1, 0, 8'h00, 32'h0,         32'h00, 16'hA500, "rd ch0 OUT"});
    vecs.push_back('{1, 0, 8'h22, 32'h0,         32'hA5, 16'hA500, "rd ch1 OUT low bits"});
    vecs.push_back('{0, 1, 8'h20, 32'h5A,        32'h00, 16'hA500, "wr unselected"});
    vecs.push_back('{1, 0, 8'h20, 32'h0,         32'hA5, 16'hA500, "rd after unselected"});
    vecs.push_back('{1, 1, 8'h2C, 32'h0F,        32'h00, 16'hA500, "wr ch1 RISE_EN"});
    vecs.push_back('{1, 0, 8'h2D, 32'h0,         32'h0F, 16'hA500, "rd ch1 RISE_EN"});
    vecs.push_back('{1, 0, 8'h24, 32'h0,         32'h00, 16'hA500, "rd ch1 IN"});
    vecs.push_back('{1, 0, 8'h34, 32'h0,         32'h00, 16'hA500, "rd ch1 PEND"});

    // Power-on reset
    rst = 1'b0; sel = 1'b1; we = 1'b0; addr = 8'h14; wd = '0; gpio_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("por gpio_out", 32'(gpio_out), 32'h0);
    check("por irq", 32'(irq), 32'h0);
    check("por PEND", rd, 32'h0);
    rst = 1'b1;
    modelReset();

    // Register table
    foreach (vecs[i]) begin
      doCycle(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, '0, r);
      check({vecs[i].name, " rd"}, r, vecs[i].expRd);
      check({vecs[i].name, " out"}, 32'(gpio_out), 32'(vecs[i].expOut));
      check({vecs[i].name, " irq"}, 32'(irq), 32'h0);
    end

`ifdef GPIO_DEBOUNCE_EN
    // Debounce: short pulse filtered, long pulse reaches PEND after 3+DB_CYCLES edges
    doCycle(1'b1, 1'b1, 8'h0C, 32'h01, '0, r);
    modelOn = 1'b0;
    for (int i = 0; i < 10; i++) doCycle(1'b1, 1'b0, 8'h14, 32'h0, 16'h0001, r);
    idle(30, 8'h14, '0, r);
    check("db short pulse PEND", r, 32'h0);
    for (int i = 1; i <= 25; i++) begin
      doCycle(1'b1, 1'b0, 8'h14, 32'h0, (i <= 20) ? 16'h0001 : 16'h0000, r);
      if (i == 19) check("db PEND after edge 18", r, 32'h0);
      if (i == 20) check("db PEND after edge 19", r, 32'h1);
    end
`else
    // Edge latency: rise on pin0 -> PEND at edge 3, irq at edge 4; fall ignored
    doCycle(1'b1, 1'b1, 8'h0C, 32'h01, '0, r);
    doCycle(1'b1, 1'b1, 8'h08, 32'h01, '0, r);
    idle(3, 8'h14, '0, r);
    doCycle(1'b1, 1'b0, 8'h14, 32'h0, 16'h0001, r);
    doCycle(1'b1, 1'b0, 8'h14, 32'h0, 16'h0001, r);
    doCycle(1'b1, 1'b0, 8'h14, 32'h0, 16'h0001, r);
    check("edge2 PEND", r, 32'h0);
    check("edge3 irq", 32'(irq), 32'h0);
    doCycle(1'b1, 1'b0, 8'h14, 32'h0, 16'h0001, r);
    check("edge3 PEND", r, 32'h1);
    check("edge4 irq", 32'(irq), 32'h1);
    idle(6, 8'h14, 16'h0000, r);
    check("fall ignored PEND", r, 32'h1);

    // W1C race: clear 0x03 in the same cycle a new rise on bit0 lands
    doCycle(1'b1, 1'b1, 8'h0C, 32'h03, '0, r);
    idle(5, 8'h14, 16'h0003, r);
    idle(5, 8'h14, 16'h0002, r);
    check("race setup PEND", r, 32'h3);
    doCycle(1'b1, 1'b0, 8'h14, 32'h0, 16'h0003, r);
    doCycle(1'b1, 1'b0, 8'h14, 32'h0, 16'h0003, r);
    doCycle(1'b1, 1'b1, 8'h14, 32'h03, 16'h0003, r);
    check("race pre-edge PEND", r, 32'h3);
    check("race edge irq", 32'(irq), 32'h1);
    doCycle(1'b1, 1'b0, 8'h14, 32'h0, 16'h0003, r);
    check("race PEND", r, 32'h1);
    check("race next irq", 32'(irq), 32'h1);

    // IE written after PEND already set: irq one edge after the write
    doCycle(1'b1, 1'b1, 8'h14, 32'hFF, 16'h0003, r);
    idle(6, 8'h34, 16'h0103, r);
    check("late IE ch1 PEND", r, 32'h1);
    check("late IE irq before", 32'(irq), 32'h0);
    doCycle(1'b1, 1'b1, 8'h28, 32'h01, 16'h0103, r);
    check("late IE irq write edge", 32'(irq), 32'h0);
    doCycle(1'b1, 1'b0, 8'h34, 32'h0, 16'h0103, r);
    check("late IE irq next edge", 32'(irq), 32'h1);

    // Mid-run asynchronous reset with PEND=0xFF
    doCycle(1'b1, 1'b1, 8'h00, 32'h3C, 16'h0100, r);
    doCycle(1'b1, 1'b1, 8'h0C, 32'hFF, 16'h0100, r);
    doCycle(1'b1, 1'b1, 8'h08, 32'hFF, 16'h0100, r);
    idle(4, 8'h14, 16'h0100, r);
    idle(5, 8'h14, 16'h01FF, r);
    check("pre-reset PEND", r, 32'hFF);
    check("pre-reset gpio_out", 32'(gpio_out), 32'hA53C);
    rst = 1'b0; sel = 1'b1; we = 1'b0; addr = 8'h14; gpio_in = 16'h01FF;
    #1;
    check("async reset PEND", rd, 32'h0);
    check("async reset gpio_out", 32'(gpio_out), 32'h0);
    check("async reset irq", 32'(irq), 32'h0);
    addr = 8'h04;
    #1;
    check("async reset IN", rd, 32'h0);
    gpio_in = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    modelReset();

    // Randomized traffic against the model
    pins = '0;
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      a = 8'(($urandom_range(0, 2) * 32) + ($urandom_range(0, 7) * 4) + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) pins = pins ^ NB'($urandom);
      doCycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, a, $urandom, pins, r);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
